// File: rtl/latency_memory.sv
// Word-addressed memory with a fixed number of access cycles per request,
// byte-enabled writes and an out-of-range error flag on the response.
module latency_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   memory_addr,
    input  logic                    memory_rden,
    input  logic                    memory_wren,
    input  logic [DATA_WIDTH/8-1:0] memory_byteen,
    input  logic [DATA_WIDTH-1:0]   memory_write_val,
    output logic [DATA_WIDTH-1:0]   memory_read_val,
    output logic                    memory_response,
    output logic                    memory_error,
    output logic                    memory_busy,
    output logic [1:0]              fsm_state
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One bit wider than both operands so the range compare never truncates.
    localparam int CMP_W = ((ADDR_WIDTH > 32) ? ADDR_WIDTH : 32) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    accept;
    logic                    fire;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NB-1:0]           be_q;
    logic                    write_q;

    logic                    in_range;
    logic [IDX_W-1:0]        idx;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (memory_rden || memory_wren) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    fire    = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request fields are captured once so later input changes cannot leak in.
    always_ff @(posedge clk) begin
        if (reset_n && accept) begin
            addr_q  <= memory_addr;
            wdata_q <= memory_write_val;
            be_q    <= memory_byteen;
            write_q <= memory_wren;
        end
    end

    assign in_range = CMP_W'(addr_q) < CMP_W'(DEPTH);
    assign idx      = IDX_W'(addr_q);

    always_ff @(posedge clk) begin
        if (reset_n && fire && write_q && in_range) begin
            for (int k = 0; k < NB; k++) begin
                if (be_q[k]) begin
                    mem[idx][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            memory_read_val <= '0;
            memory_response <= 1'b0;
            memory_error    <= 1'b0;
        end else begin
            memory_response <= fire;
            memory_error    <= fire && !in_range;
            if (fire && !write_q) begin
                memory_read_val <= in_range ? mem[idx] : '0;
            end
        end
    end

    assign memory_busy = (state_q != IDLE);
    assign fsm_state   = state_q;

endmodule

// File: tb/tb_latency_memory.sv
// Bench for latency_memory: three instances (LATENCY 1, 2, 3) exercised with
// a vector table, a response scoreboard and hand-written corner sequences.
module tb_latency_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // LATENCY=2 instance
    logic        r2_n, rd2, wr2;
    logic [31:0] a2, wv2, rv2;
    logic [3:0]  be2;
    logic        resp2, err2, busy2;
    logic [1:0]  st2;
    // LATENCY=3 instance
    logic        r3_n, rd3, wr3;
    logic [31:0] a3, wv3, rv3;
    logic [3:0]  be3;
    logic        resp3, err3, busy3;
    logic [1:0]  st3;
    // LATENCY=1 instance
    logic        r1_n, rd1, wr1;
    logic [31:0] a1, wv1, rv1;
    logic [3:0]  be1;
    logic        resp1, err1, busy1;
    logic [1:0]  st1;

    latency_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(1024), .LATENCY(2)) u2 (
        .clk(clk), .reset_n(r2_n), .memory_addr(a2), .memory_rden(rd2), .memory_wren(wr2),
        .memory_byteen(be2), .memory_write_val(wv2), .memory_read_val(rv2),
        .memory_response(resp2), .memory_error(err2), .memory_busy(busy2), .fsm_state(st2));

    latency_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(1024), .LATENCY(3)) u3 (
        .clk(clk), .reset_n(r3_n), .memory_addr(a3), .memory_rden(rd3), .memory_wren(wr3),
        .memory_byteen(be3), .memory_write_val(wv3), .memory_read_val(rv3),
        .memory_response(resp3), .memory_error(err3), .memory_busy(busy3), .fsm_state(st3));

    latency_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(1024), .LATENCY(1)) u1 (
        .clk(clk), .reset_n(r1_n), .memory_addr(a1), .memory_rden(rd1), .memory_wren(wr1),
        .memory_byteen(be1), .memory_write_val(wv1), .memory_read_val(rv1),
        .memory_response(resp1), .memory_error(err1), .memory_busy(busy1), .fsm_state(st1));

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard for u2: {error, read_val} expected per response.
    logic [32:0] exp_q[$];
    int          resp_cnt2  = 0;
    int          err_stray2 = 0;

    always @(negedge clk) begin
        if (r2_n && !resp2 && err2) err_stray2++;
        if (resp2) begin
            resp_cnt2++;
            check("resp_pending", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("resp_data", {err2, rv2}, e);
            end
        end
    end

    typedef struct {
        logic [1:0]  op;      // 1 read, 2 write, 3 read+write
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[$];

    task automatic wait_idle2(input string name);
        int k;
        k = 0;
        while (busy2 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(busy2), 64'd0);
    endtask

    task automatic issue2(input vec_t v);
        exp_q.push_back({v.err, v.rd});
        rd2 = v.op[0]; wr2 = v.op[1]; a2 = v.addr; wv2 = v.data; be2 = v.be;
        @(negedge clk);
        rd2 = 1'b0; wr2 = 1'b0;
        wait_idle2("idle_after_req");
    endtask

    task automatic xfer3(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                         output logic [31:0] rv, output logic ok);
        rd3 = op[0]; wr3 = op[1]; a3 = addr; wv3 = data; be3 = 4'hF;
        @(negedge clk);
        rd3 = 1'b0; wr3 = 1'b0;
        ok = 1'b0;
        rv = '0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (resp3) begin
                ok = 1'b1;
                rv = rv3;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rv;
        logic        ok;
        int          r0;
        int          hits[$];

        tbl.push_back('{2'd1, 32'd5,          32'h0,        4'hF, 1'b0, 32'hDEADBEEF});
        tbl.push_back('{2'd2, 32'd7,          32'h11223344, 4'hF, 1'b0, 32'hDEADBEEF});
        tbl.push_back('{2'd2, 32'd7,          32'hAABBCCDD, 4'h5, 1'b0, 32'hDEADBEEF});
        tbl.push_back('{2'd1, 32'd7,          32'h0,        4'hF, 1'b0, 32'h11BB33DD});
        tbl.push_back('{2'd2, 32'd3,          32'hCAFEF00D, 4'hF, 1'b0, 32'h11BB33DD});
        tbl.push_back('{2'd1, 32'd1024,       32'h0,        4'hF, 1'b1, 32'h0});
        tbl.push_back('{2'd2, 32'h0001_0003,  32'h12345678, 4'hF, 1'b1, 32'h0});
        tbl.push_back('{2'd1, 32'd3,          32'h0,        4'hF, 1'b0, 32'hCAFEF00D});
        tbl.push_back('{2'd2, 32'd9,          32'hA5A5A5A5, 4'hF, 1'b0, 32'hCAFEF00D});
        tbl.push_back('{2'd2, 32'd9,          32'hFFFFFFFF, 4'h0, 1'b0, 32'hCAFEF00D});
        tbl.push_back('{2'd1, 32'd9,          32'h0,        4'hF, 1'b0, 32'hA5A5A5A5});
        tbl.push_back('{2'd1, 32'hFFFF_FFFF,  32'h0,        4'hF, 1'b1, 32'h0});
        tbl.push_back('{2'd2, 32'd1023,       32'h01020304, 4'hF, 1'b0, 32'h0});
        tbl.push_back('{2'd1, 32'd1023,       32'h0,        4'hF, 1'b0, 32'h01020304});
        tbl.push_back('{2'd2, 32'd5,          32'h0,        4'hA, 1'b0, 32'h01020304});
        tbl.push_back('{2'd1, 32'd5,          32'h0,        4'hF, 1'b0, 32'h00AD00EF});

        r2_n = 0; rd2 = 0; wr2 = 0; a2 = 0; wv2 = 0; be2 = 0;
        r3_n = 0; rd3 = 0; wr3 = 0; a3 = 0; wv3 = 0; be3 = 0;
        r1_n = 0; rd1 = 0; wr1 = 0; a1 = 0; wv1 = 0; be1 = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {rv2, resp2, err2, busy2}, 64'd0);
        rd2 = 1'b1;
        @(negedge clk);
        check("no_accept_in_reset", 64'(busy2), 64'd0);
        rd2 = 1'b0;
        r2_n = 1; r3_n = 1; r1_n = 1;
        @(negedge clk);

        // Timed write on LATENCY=2: cycle 0 request, busy 1..3, response in 3.
        exp_q.push_back({1'b0, 32'h0});
        wr2 = 1'b1; a2 = 32'd5; wv2 = 32'hDEADBEEF; be2 = 4'hF;
        @(negedge clk);
        wr2 = 1'b0;
        check("c1_busy_resp", {busy2, resp2}, 64'b10);
        @(negedge clk);
        check("c2_busy_resp", {busy2, resp2}, 64'b10);
        @(negedge clk);
        check("c3_busy_resp_err", {busy2, resp2, err2}, 64'b110);
        @(negedge clk);
        check("c4_busy_resp", {busy2, resp2}, 64'b00);

        foreach (tbl[i]) issue2(tbl[i]);

        // Read+write together is a write; inputs and rden pulses while busy are ignored.
        r0 = resp_cnt2;
        exp_q.push_back({1'b0, 32'h00AD00EF});
        rd2 = 1'b1; wr2 = 1'b1; a2 = 32'd9; wv2 = 32'h5; be2 = 4'hF;
        @(negedge clk);
        wr2 = 1'b0; a2 = 32'd3; wv2 = 32'hFFFF0000; be2 = 4'h0;
        repeat (3) @(negedge clk);
        rd2 = 1'b0;
        repeat (6) @(negedge clk);
        check("single_resp_while_busy", 64'(resp_cnt2 - r0), 64'd1);
        issue2('{2'd1, 32'd9, 32'h0, 4'hF, 1'b0, 32'h5});
        issue2('{2'd1, 32'd3, 32'h0, 4'hF, 1'b0, 32'hCAFEF00D});

        // LATENCY=3: reset in the second ACCESS cycle drops the write.
        xfer3(2'd2, 32'd2, 32'h11, rv, ok);
        check("u3_w2_done", 64'(ok), 64'd1);
        xfer3(2'd2, 32'd4, 32'h44, rv, ok);
        check("u3_w4_done", 64'(ok), 64'd1);
        xfer3(2'd1, 32'd2, 32'h0, rv, ok);
        check("u3_rd2_before", {ok, rv}, {1'b1, 32'h11});
        wr3 = 1'b1; a3 = 32'd2; wv3 = 32'h77; be3 = 4'hF;
        @(negedge clk);
        wr3 = 1'b0;
        @(negedge clk);
        check("u3_inflight_busy", 64'(busy3), 64'd1);
        r3_n = 1'b0;
        @(negedge clk);
        check("u3_reset_outputs", {rv3, resp3, err3, busy3}, 64'd0);
        r3_n = 1'b1;
        r0 = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (resp3) r0++;
        end
        check("u3_no_resp_after_reset", 64'(r0), 64'd0);
        xfer3(2'd1, 32'd2, 32'h0, rv, ok);
        check("u3_rd2_after", {ok, rv}, {1'b1, 32'h11});
        xfer3(2'd1, 32'd4, 32'h0, rv, ok);
        check("u3_rd4_after", {ok, rv}, {1'b1, 32'h44});

        // LATENCY=1: continuous rden gives one response every 3 cycles.
        a1 = 32'd2000; rd1 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (resp1) begin
                hits.push_back(c);
                if (hits.size() == 1) check("u1_oor_read", {err1, rv1}, {1'b1, 32'h0});
            end
        end
        rd1 = 1'b0;
        check("u1_resp_count", 64'(hits.size()), 64'd4);
        foreach (hits[i]) check("u1_resp_cycle", 64'(hits[i]), 64'(2 + 3 * i));

        repeat (4) @(negedge clk);
        check("stray_error", 64'(err_stray2), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/latency_memory.md
LATENCY_MEMORY -- requirements
Module: latency_memory

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 32: width of memory_addr.
REQ-003 Parameter DEPTH, default 1024: number of words stored.
REQ-004 Parameter LATENCY, default 1: number of ACCESS cycles per request; SHALL be >= 1.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  reset, synchronous, active-low.
REQ-007 memory_addr  input  ADDR_WIDTH  word index of the access.
REQ-008 memory_rden  input  1  read request.
REQ-009 memory_wren  input  1  write request.
REQ-010 memory_byteen  input  DATA_WIDTH/8  per-byte write enable; bit k covers bits [8k+7:8k].
REQ-011 memory_write_val  input  DATA_WIDTH  write data.
REQ-012 memory_read_val  output  DATA_WIDTH  read data, registered.
REQ-013 memory_response  output  1  one-cycle completion pulse.
REQ-014 memory_error  output  1  out-of-range flag, valid with memory_response.
REQ-015 memory_busy  output  1  high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have three states, IDLE, ACCESS and RESP, plus a latency counter of width clog2(LATENCY+1).
REQ-017 Requests SHALL be sampled only in IDLE; rden/wren in ACCESS or RESP SHALL be ignored.
REQ-018 In IDLE with rden or wren high: latch addr, write_val, byteen and op (write if wren, else read); counter := LATENCY-1; go to ACCESS.
REQ-019 rden and wren high together SHALL be treated as a write.
REQ-020 In ACCESS: if counter = 0, go to RESP; otherwise decrement the counter and stay.
REQ-021 The edge entering RESP SHALL perform the array access and assert memory_response for exactly one cycle (the RESP cycle).
REQ-022 RESP SHALL always go to IDLE; the earliest next request is accepted in the following cycle.
REQ-023 Latency: a request sampled in IDLE at cycle t SHALL produce memory_response high in cycle t+LATENCY+1; back-to-back throughput is one request per LATENCY+2 cycles.
REQ-024 A latched address is in range iff it is < DEPTH; the upper address bits SHALL be compared, not truncated.
REQ-025 In-range write: only bytes with byteen=1 are updated; byteen=0 on every bit SHALL complete normally with no array change.
REQ-026 In-range read: memory_read_val := the full word; it SHALL hold until the next read response.
REQ-027 Out-of-range access: memory_error=1 during RESP; no write is performed; a read SHALL return 0 on memory_read_val.
REQ-028 memory_error SHALL be 0 whenever memory_response is 0.
REQ-029 Inputs changing after acceptance SHALL NOT affect the in-flight operation.

Reset
REQ-030 While reset_n=0 at an edge: state := IDLE, counter := 0, memory_read_val := 0, memory_response := 0, memory_error := 0, memory_busy := 0.
REQ-031 Reset SHALL NOT clear the array contents.
REQ-032 On reset during ACCESS, the pending write SHALL be discarded and no response SHALL issue.
REQ-033 Requests SHALL NOT be accepted during a cycle with reset_n=0.

Verification
REQ-034 LATENCY=2; write addr 5, data 0xDEADBEEF, byteen 0xF in cycle 0 -> busy high in cycles 1-3, response high only in cycle 3, error 0; then read addr 5 -> read_val 0xDEADBEEF with response high.
REQ-035 Word 7 = 0x11223344; write 0xAABBCCDD to addr 7 with byteen 0x5 -> reading addr 7 returns 0x11BB33DD.
REQ-036 Read addr 1024 (DEPTH 1024) -> response and error both 1 for one cycle, read_val 0; then write addr 0x0001_0003 -> error 1 and word 3 unchanged.
REQ-037 rden=wren=1, addr 9, data 0x5 -> treated as a write, so word 9 = 5; rden pulsed while busy -> no extra response.
REQ-038 LATENCY=3, write addr 2 = 0x77, reset_n=0 in the second ACCESS cycle -> no response, all outputs 0, word 2 keeps its old value; prior array data is preserved.
REQ-039 LATENCY=1, continuous rden=1 -> response once every 3 cycles.
